// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and default geometry for the camera frame writer
package cam_pkg;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;
  localparam int FB_DEPTH     = DEF_H_PIXELS * DEF_V_LINES;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE
  } fsm_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - registered input with rising/falling edge pulses
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      q      <= d;
      q_prev <= q;
    end
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - OV7670-style byte stream to linear RGB565 frame-buffer writes
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES,
  parameter int ADDR_W   = $clog2(FB_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        din,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              line_err,
  output logic [7:0]        frame_cnt
);

  localparam int X_W = $clog2(H_PIXELS + 1) + 1;
  localparam int Y_W = $clog2(V_LINES + 1);
  localparam logic [X_W-1:0]    X_MAX = '1;
  localparam logic [X_W-1:0]    H_X   = X_W'(H_PIXELS);
  localparam logic [Y_W-1:0]    V_Y   = Y_W'(V_LINES);
  localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(H_PIXELS);

  fsm_t              state, state_nxt;
  logic              vs_r, vs_rise, vs_fall;
  logic              hr_r, hr_rise, hr_fall;
  logic [7:0]        din_r, hi;
  logic              phase;
  logic [X_W-1:0]    x, x_post;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr, addr_post;
  rgb565_t           pix_q;

  logic start, active, phase_eff, take_hi, take_lo, keep_pix;
  logic line_end, frame_end, abort;

  sync_edge_det u_vs (
    .clk(clk), .reset(reset), .d(vsync), .q(vs_r), .rise(vs_rise), .fall(vs_fall)
  );

  sync_edge_det u_hr (
    .clk(clk), .reset(reset), .d(href), .q(hr_r), .rise(hr_rise), .fall(hr_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_r <= 8'd0;
      state <= IDLE;
    end else begin
      din_r <= din;
      state <= state_nxt;
    end
  end

  // capture_en is only looked at when leaving IDLE or closing a frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_en) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (frame_end || vs_rise) state_nxt = capture_en ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    active = 1'b0;
    case (state)
      WAIT_VS: start = vs_fall;
      ACTIVE:  active = 1'b1;
      default: ;
    endcase
  end

  // A new href pulse always begins on a high byte, whatever phase was left behind
  always_comb begin
    phase_eff = phase & ~hr_rise;
    take_lo   = active & hr_r & phase_eff;
    take_hi   = active & hr_r & ~phase_eff;
    keep_pix  = take_lo & (x < H_X);
    x_post    = (take_lo && x != X_MAX) ? x + 1'b1 : x;
    addr_post = keep_pix ? addr + 1'b1 : addr;
    line_end  = active & hr_fall;
    frame_end = line_end & ((y + 1'b1) == V_Y);
    abort     = active & vs_rise & ~frame_end;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we         <= 1'b0;
      wAddr      <= '0;
      pix_q      <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= 8'd0;
      hi         <= 8'd0;
      phase      <= 1'b0;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        x        <= '0;
        y        <= '0;
        addr     <= '0;
        phase    <= 1'b0;
        line_err <= 1'b0;
      end else if (active) begin
        if (take_hi) begin
          hi    <= din_r;
          phase <= 1'b1;
        end
        if (take_lo) begin
          phase <= 1'b0;
          if (keep_pix) begin
            we    <= 1'b1;
            pix_q <= {hi, din_r};
            wAddr <= addr;
          end
        end
        if (line_end) begin
          x     <= '0;
          y     <= y + 1'b1;
          phase <= 1'b0;
          if (x_post != H_X) line_err <= 1'b1;
          // short line: skip the unwritten tail so the next line stays row-aligned
          addr <= (x_post < H_X) ? addr_post + (H_A - ADDR_W'(x_post)) : addr_post;
          if (frame_end) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        end else begin
          x    <= x_post;
          addr <= addr_post;
        end
        if (abort) line_err <= 1'b1;
      end
    end
  end

  assign wData = pix_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - randomized frame stimulus checked against a line-level reference model
module tb_cam_frame_writer;

  localparam int H  = 20;
  localparam int V  = 12;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          capture_en = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    din = 8'd0;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  logic          frame_done;
  logic          line_err;
  logic [7:0]    frame_cnt;

  cam_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .vsync(vsync), .href(href),
    .din(din), .we(we), .wAddr(wAddr), .wData(wData), .frame_done(frame_done),
    .line_err(line_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  cyc = 0;
  int  n_pass = 0;
  int  n_chk = 0;
  int  done_seen = 0;
  int  max_addr = 0;
  bit  mon_on = 1'b0;
  int  exp_cnt = 0;
  bit  exp_err = 1'b0;
  int  line_len[V];
  bit  line_odd[V];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      if (frame_done) done_seen++;
      if (we) begin
        if (int'(wAddr) > max_addr) max_addr = int'(wAddr);
        if (exp_q.size() == 0) check("extra_we", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("waddr", int'(wAddr), e.addr);
          check("wdata", int'(wData), e.data);
          check("latency", cyc - e.cyc, 2);
        end
      end
    end
  end

  task automatic put(input bit h, input logic [7:0] d);
    @(negedge clk);
    href = h;
    din  = d;
  endtask

  task automatic vs_pulse();
    @(negedge clk) vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // a frame is captured iff capture_en is high when it starts; line l pixel p lands at l*H+p
  task automatic send_frame(input int abort_line, input int drop_line, input bit fixed);
    bit          cap;
    bit          err;
    bit          aborted;
    logic [15:0] d;
    cap     = capture_en;
    err     = 1'b0;
    aborted = 1'b0;
    vs_pulse();
    if (cap) check("lerr_clr", int'(line_err), 0);
    for (int l = 0; l < V; l++) begin
      if (!aborted) begin
        if (l == abort_line) begin
          @(negedge clk) vsync = 1'b1;
          aborted = 1'b1;
          err     = 1'b1;
        end else begin
          if (l == drop_line) capture_en = 1'b0;
          if (line_len[l] != H) err = 1'b1;
          for (int p = 0; p < line_len[l]; p++) begin
            d = fixed ? 16'hF81F : 16'($urandom);
            put(1'b1, d[15:8]);
            put(1'b1, d[7:0]);
            if (cap && p < H) exp_q.push_back('{l * H + p, int'(d), cyc});
          end
          if (line_odd[l]) put(1'b1, 8'($urandom));
          repeat (3) put(1'b0, 8'd0);
        end
      end
    end
    repeat (4) @(negedge clk);
    if (cap) begin
      exp_err = err;
      if (!aborted) exp_cnt = (exp_cnt + 1) % 256;
    end
    check("missing_we", exp_q.size(), 0);
    exp_q.delete();
    check("frame_done", done_seen, (cap && !aborted) ? 1 : 0);
    done_seen = 0;
    check("line_err", int'(line_err), int'(exp_err));
    check("frame_cnt", int'(frame_cnt), exp_cnt);
  endtask

  task automatic plain_lines();
    for (int l = 0; l < V; l++) begin
      line_len[l] = H;
      line_odd[l] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vsync      = 1'($urandom);
      href       = 1'($urandom);
      din        = 8'($urandom);
      capture_en = 1'($urandom);
      #1;
      check("rst_we", int'(we), 0);
      check("rst_waddr", int'(wAddr), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_cnt", int'(frame_cnt), 0);
      check("rst_lerr", int'(line_err), 0);
    end
    @(negedge clk);
    vsync = 1'b0;
    href  = 1'b0;
    din   = 8'd0;
    capture_en = 1'b0;
    reset = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    capture_en = 1'b1;

    plain_lines();
    send_frame(-1, -1, 1'b1);

    plain_lines();
    line_len[5] = H - 2;
    send_frame(-1, -1, 1'b0);

    plain_lines();
    line_len[0] = H + 10;
    line_odd[3] = 1'b1;
    send_frame(-1, -1, 1'b0);

    plain_lines();
    send_frame(-1, V / 2, 1'b0);
    send_frame(-1, -1, 1'b0);

    capture_en = 1'b1;
    plain_lines();
    send_frame(5, -1, 1'b0);
    send_frame(-1, -1, 1'b0);

    for (int f = 0; f < 5; f++) begin
      for (int l = 0; l < V; l++) begin
        line_len[l] = ($urandom_range(0, 3) != 0) ? H : H + int'($urandom_range(0, 6)) - 3;
        line_odd[l] = 1'($urandom_range(0, 3) == 0);
      end
      send_frame(-1, -1, 1'b0);
    end

    mon_on = 1'b0;
    vs_pulse();
    put(1'b1, 8'hAA);
    put(1'b1, 8'h55);
    @(posedge clk);
    @(posedge clk);
    #1 check("we_pre_rst", int'(we), 1);
    #1 reset = 1'b0;
    #1;
    check("arst_we", int'(we), 0);
    check("arst_waddr", int'(wAddr), 0);
    check("arst_cnt", int'(frame_cnt), 0);
    check("arst_lerr", int'(line_err), 0);
    @(negedge clk);
    href  = 1'b0;
    din   = 8'd0;
    reset = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
    done_seen = 0;
    mon_on = 1'b1;
    plain_lines();
    send_frame(-1, -1, 1'b0);

    check("addr_max", (max_addr <= H * V - 1) ? 1 : 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
